// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt controller for the M stage: SR/Cause/EPC, flush request,
// mfc0/mtc0/eret handling.
module cp0_exc_unit #(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exc_code_m,
    input  logic        ov_arith,
    input  logic        ov_load,
    input  logic        ov_store,
    input  logic [5:0]  hwint,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic        eret_m,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc_out,
    output logic        exc_req,
    output logic [31:0] handler_pc
);

    localparam logic [4:0] AddrSr    = 5'd12;
    localparam logic [4:0] AddrCause = 5'd13;
    localparam logic [4:0] AddrEpc   = 5'd14;

    localparam logic [4:0] CodeOv   = 5'd12;
    localparam logic [4:0] CodeAdEL = 5'd4;
    localparam logic [4:0] CodeAdES = 5'd5;

    // The handler state is SR.EXL itself.
    typedef enum logic {StNormal, StHandler} state_e;

    state_e      state_q;
    logic [5:0]  sr_im_q;
    logic        sr_ie_q;
    logic        cause_bd_q;
    logic [5:0]  cause_ip_q;
    logic [4:0]  cause_exc_q;
    logic [31:0] epc_q;

    logic        sr_exl;
    logic [4:0]  eff_code;
    logic        int_pend;
    logic        exc_pend;
    logic        mtc0_sr;
    logic        mtc0_epc;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign sr_exl = (state_q == StHandler);

    always_comb begin
        eff_code = 5'd0;
        if (exc_code_m != 5'd0) begin
            eff_code = exc_code_m;
        end else if (ov_arith) begin
            eff_code = CodeOv;
        end else if (ov_load) begin
            eff_code = CodeAdEL;
        end else if (ov_store) begin
            eff_code = CodeAdES;
        end
    end

    assign int_pend = (|(hwint & sr_im_q)) & sr_ie_q & ~sr_exl;
    assign exc_pend = (eff_code != 5'd0) & ~sr_exl;
    // Registers are cleared during reset, so gate the request explicitly as well.
    assign exc_req  = rst_n & (int_pend | exc_pend);

    assign mtc0_sr  = cp0_we & (cp0_addr == AddrSr);
    assign mtc0_epc = cp0_we & (cp0_addr == AddrEpc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StNormal;
            sr_im_q     <= 6'd0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            cause_ip_q <= hwint;
            if (exc_req) begin
                state_q     <= StHandler;
                cause_exc_q <= int_pend ? 5'd0 : eff_code;
                cause_bd_q  <= bd_m;
                epc_q       <= bd_m ? (pc_m - 32'd4) : pc_m;
            end else begin
                if (mtc0_sr) begin
                    sr_im_q <= cp0_wdata[15:10];
                    sr_ie_q <= cp0_wdata[0];
                    state_q <= cp0_wdata[1] ? StHandler : StNormal;
                end else if (eret_m) begin
                    state_q <= StNormal;
                end
                if (mtc0_epc) begin
                    epc_q <= cp0_wdata;
                end
            end
        end
    end

    assign sr_val    = {16'd0, sr_im_q, 8'd0, sr_exl, sr_ie_q};
    assign cause_val = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            AddrSr:    cp0_rdata = sr_val;
            AddrCause: cp0_rdata = cause_val;
            AddrEpc:   cp0_rdata = epc_q;
            default:   cp0_rdata = 32'd0;
        endcase
    end

    assign epc_out    = epc_q;
    assign handler_pc = EXC_ENTRY;

endmodule
